// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches ps2c/ps2d, deserializes
// 11-bit frames, strips E0/F0 prefixes and strobes out one scan code at a time.
module ps2_scancode_rx #(
  parameter int unsigned N          = 8,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000,
  parameter int unsigned TW         = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ps2c,
  input  logic         ps2d,
  input  logic         rx_en,
  output logic [N-1:0] scan_code,
  output logic         break_flag,
  output logic         ext_flag,
  output logic         code_tick,
  output logic         err_tick
);

  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    BYTE_EXT     = 8'hE0;
  localparam logic [7:0]    BYTE_BREAK   = 8'hF0;

  typedef enum logic [1:0] {IDLE, DPS, LOAD} state_t;

  state_t                state;
  logic [1:0]            c_sync;
  logic [1:0]            d_sync;
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  filt_clk;
  logic [3:0]            bit_cnt;
  logic [TW-1:0]         tcount;
  logic [9:0]            frame_sr;
  logic                  ext_pending;
  logic                  break_pending;

  logic                  fall_edge_c;
  logic                  frame_ok_c;
  logic [7:0]            frame_byte_c;

  // Filtered clock is about to drop: a one-cycle pulse ahead of the level change.
  assign fall_edge_c  = filt_clk & (filt_sr == '0);
  // Stop bit high and odd parity over data plus parity bit.
  assign frame_ok_c   = frame_sr[9] & (^frame_sr[8:0]);
  assign frame_byte_c = frame_sr[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      c_sync        <= 2'b11;
      d_sync        <= 2'b11;
      filt_sr       <= '1;
      filt_clk      <= 1'b1;
      bit_cnt       <= 4'd0;
      tcount        <= '0;
      frame_sr      <= 10'd0;
      ext_pending   <= 1'b0;
      break_pending <= 1'b0;
      scan_code     <= '0;
      break_flag    <= 1'b0;
      ext_flag      <= 1'b0;
      code_tick     <= 1'b0;
      err_tick      <= 1'b0;
    end else begin
      c_sync    <= {c_sync[0], ps2c};
      d_sync    <= {d_sync[0], ps2d};
      filt_sr   <= {c_sync[1], filt_sr[FILTER_LEN-1:1]};
      if (filt_sr == '1) begin
        filt_clk <= 1'b1;
      end else if (filt_sr == '0) begin
        filt_clk <= 1'b0;
      end
      code_tick <= 1'b0;
      err_tick  <= 1'b0;

      case (state)
        IDLE: begin
          if (fall_edge_c && !d_sync[1] && rx_en) begin
            state   <= DPS;
            bit_cnt <= 4'd9;
            tcount  <= '0;
          end
        end
        DPS: begin
          if (fall_edge_c) begin
            frame_sr <= {d_sync[1], frame_sr[9:1]};
            tcount   <= '0;
            if (bit_cnt == 4'd0) begin
              state <= LOAD;
            end else begin
              bit_cnt <= bit_cnt - 4'd1;
            end
          end else if (tcount == TIMEOUT_LAST) begin
            // Sender stalled mid-frame: drop it along with any pending prefix.
            state         <= IDLE;
            err_tick      <= 1'b1;
            ext_pending   <= 1'b0;
            break_pending <= 1'b0;
          end else begin
            tcount <= tcount + TW'(1);
          end
        end
        LOAD: begin
          state <= IDLE;
          if (!frame_ok_c) begin
            err_tick      <= 1'b1;
            ext_pending   <= 1'b0;
            break_pending <= 1'b0;
          end else if (frame_byte_c == BYTE_EXT) begin
            ext_pending <= 1'b1;
          end else if (frame_byte_c == BYTE_BREAK) begin
            break_pending <= 1'b1;
          end else begin
            scan_code     <= N'(frame_byte_c);
            break_flag    <= break_pending;
            ext_flag      <= ext_pending;
            code_tick     <= 1'b1;
            ext_pending   <= 1'b0;
            break_pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: cycle-level behavioural model plus directed and
// randomized PS/2 frames, with a few literal expectations.
module tb_ps2_scancode_rx;

  localparam int FL = 8;
  localparam int TO = 400;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rx_en = 1'b1;
  logic [7:0] scan_code;
  logic       break_flag;
  logic       ext_flag;
  logic       code_tick;
  logic       err_tick;

  ps2_scancode_rx #(.N(8), .FILTER_LEN(FL), .TIMEOUT(TO), .TW(16)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .scan_code(scan_code), .break_flag(break_flag), .ext_flag(ext_flag),
    .code_tick(code_tick), .err_tick(err_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int code_cnt = 0;
  int err_cnt = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  // Pads reach the logic two samples late; the clock level only changes once
  // FL consecutive samples agree; a frame is 10 bits gathered after a start bit.
  logic       m_c1, m_c2, m_d1, m_d2, m_last, m_filt;
  int         m_run, m_nbits, m_gap;
  bit         m_in, m_load, m_ext_p, m_brk_p;
  logic [9:0] m_word;
  logic [7:0] m_scan, m_byte;
  logic       m_brk, m_ext, m_code, m_err;
  bit         fe;
  logic       d_now;

  always @(posedge clk) begin
    if (reset) begin
      m_c1 = 1; m_c2 = 1; m_d1 = 1; m_d2 = 1; m_last = 1; m_run = FL; m_filt = 1;
      m_in = 0; m_load = 0; m_ext_p = 0; m_brk_p = 0; m_nbits = 0; m_gap = 0;
      m_word = '0; m_scan = 8'h00; m_brk = 0; m_ext = 0; m_code = 0; m_err = 0;
    end else begin
      fe    = m_filt && (m_run >= FL) && (m_last == 1'b0);
      d_now = m_d2;
      if (m_run >= FL) m_filt = m_last;
      if (m_c2 == m_last) begin
        if (m_run < FL) m_run++;
      end else begin
        m_last = m_c2;
        m_run  = 1;
      end
      m_c2 = m_c1; m_c1 = ps2c; m_d2 = m_d1; m_d1 = ps2d;
      m_code = 0; m_err = 0;
      if (m_load) begin
        m_load = 0;
        m_byte = m_word[7:0];
        if (m_word[9] && ($countones(m_word[8:0]) % 2 == 1)) begin
          if (m_byte == 8'hE0) m_ext_p = 1;
          else if (m_byte == 8'hF0) m_brk_p = 1;
          else begin
            m_scan = m_byte; m_brk = m_brk_p; m_ext = m_ext_p; m_code = 1;
            m_ext_p = 0; m_brk_p = 0;
          end
        end else begin
          m_err = 1; m_ext_p = 0; m_brk_p = 0;
        end
      end else if (m_in) begin
        if (fe) begin
          m_word[m_nbits] = d_now;
          m_nbits++;
          m_gap = 0;
          if (m_nbits == 10) begin
            m_in = 0;
            m_load = 1;
          end
        end else if (m_gap == TO - 1) begin
          m_in = 0; m_err = 1; m_ext_p = 0; m_brk_p = 0;
        end else begin
          m_gap++;
        end
      end else if (fe && d_now == 1'b0 && rx_en) begin
        m_in = 1; m_nbits = 0; m_gap = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({scan_code, break_flag, ext_flag, code_tick, err_tick} !==
          {m_scan, m_brk, m_ext, m_code, m_err}) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t got scan=%h brk=%b ext=%b code=%b err=%b exp scan=%h brk=%b ext=%b code=%b err=%b",
                 $time, scan_code, break_flag, ext_flag, code_tick, err_tick,
                 m_scan, m_brk, m_ext, m_code, m_err);
      end
      if (code_tick === 1'b1) code_cnt++;
      if (err_tick === 1'b1) err_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2d = b;
    wait_cyc($urandom_range(12, 25));
    ps2c = 1'b0;
    wait_cyc($urandom_range(12, 25));
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input bit par_bad, input bit stop_bad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit((~^data) ^ par_bad);
    send_bit(~stop_bad);
    ps2d = 1'b1;
    wait_cyc(40);
  endtask

  task automatic glitch(input int len);
    ps2c = 1'b0;
    wait_cyc(len);
    ps2c = 1'b1;
    wait_cyc(20);
  endtask

  int c0, e0;

  initial begin
    wait_cyc(3);
    reset = 1'b0;
    chk_en = 1'b1;
    wait_cyc(2);
    check("reset_outputs", {24'd0, scan_code}, 32'h0);
    check("reset_strobes", {29'd0, break_flag, ext_flag, code_tick}, 32'h0);

    c0 = code_cnt; e0 = err_cnt;
    send_frame(8'h1C, 0, 0);
    check("make_1c_ticks", code_cnt - c0, 1);
    check("make_1c_errs", err_cnt - e0, 0);
    check("make_1c_code", {24'd0, scan_code}, 32'h1C);
    check("make_1c_flags", {30'd0, break_flag, ext_flag}, 0);
    check("model_pin_1c", {24'd0, m_scan}, 32'h1C);

    c0 = code_cnt;
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    check("break_1c_ticks", code_cnt - c0, 1);
    check("break_1c_flag", {31'd0, break_flag}, 1);
    send_frame(8'h1C, 0, 0);
    check("after_break_flag", {31'd0, break_flag}, 0);

    c0 = code_cnt;
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    check("ext_break_ticks", code_cnt - c0, 1);
    check("ext_break_out", {21'd0, scan_code, break_flag, ext_flag, code_tick}, {21'd0, 8'h75, 3'b110});

    c0 = code_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1, 0);
    check("parity_err", err_cnt - e0, 1);
    check("parity_hold", {24'd0, scan_code}, 32'h75);
    send_frame(8'h1C, 0, 1);
    check("stop_err", err_cnt - e0, 2);
    check("err_no_code", code_cnt - c0, 0);

    e0 = err_cnt; c0 = code_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    wait_cyc(TO + 60);
    check("timeout_err", err_cnt - e0, 1);
    send_frame(8'h29, 0, 0);
    check("after_timeout_code", {24'd0, scan_code}, 32'h29);
    check("after_timeout_ticks", code_cnt - c0, 1);

    c0 = code_cnt; e0 = err_cnt;
    for (int i = 0; i < 6; i++) glitch($urandom_range(1, FL - 1));
    glitch(FL - 1);
    check("glitch_quiet", (code_cnt - c0) + (err_cnt - e0), 0);

    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ps2d = 1'b1;
    check("midreset_out", {21'd0, scan_code, break_flag, ext_flag, code_tick}, 0);
    check("midreset_err", {31'd0, err_tick}, 0);
    c0 = code_cnt; e0 = err_cnt;
    wait_cyc(TO + 60);
    check("midreset_quiet", (code_cnt - c0) + (err_cnt - e0), 0);

    c0 = code_cnt;
    rx_en = 1'b0;
    send_frame(8'h1C, 0, 0);
    rx_en = 1'b1;
    check("rx_en_off_ignored", code_cnt - c0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      int sel;
      sel = int'($urandom_range(0, 9));
      b = 8'($urandom);
      if (sel == 0) b = 8'hE0;
      else if (sel == 1) b = 8'hF0;
      rx_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 5) == 0) glitch($urandom_range(1, FL - 1));
      send_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end
    rx_en = 1'b1;
    wait_cyc(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
